// File: rtl/acc_config_rx.sv
// acc_config_rx: HPS configuration-channel receiver that loads the SAD lambda and writes LCU payload words into block RAM.
module acc_config_rx #(
    parameter int LCU_WORDS = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       channel_data,
    input  logic              channel_lz,
    output logic              channel_vz,
    input  logic              sw_clear,
    input  logic              lambda_clr,
    input  logic              lcu_clr,
    output logic [31:0]       lambda,
    output logic              lambda_loaded,
    output logic              lcu_loaded,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [31:0]       buf_wdata,
    output logic              err
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAMBDA, S_LCU, S_DISCARD} state_t;
    localparam logic [3:0]  T_LAMBDA = 4'h1;
    localparam logic [3:0]  T_LCU    = 4'h2;
    localparam logic [16:0] MAX_N    = 17'(LCU_WORDS);
    state_t state_q, state_d;
    logic is_lcu_q, is_lcu_d;
    logic [15:0] len_q, len_d, cnt_q, cnt_d;
    logic [31:0] lambda_q, lambda_d;
    logic lambda_loaded_q, lambda_loaded_d, lcu_loaded_q, lcu_loaded_d;
    logic buf_we_q, buf_we_d, err_q, err_d, vz_q, vz_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [31:0] buf_wdata_q, buf_wdata_d;
    logic acc, set_lambda, set_lcu;
    logic [3:0] hdr_type;
    logic [15:0] hdr_n;
    assign acc      = channel_lz & vz_q;
    assign hdr_type = channel_data[31:28];
    assign hdr_n    = channel_data[15:0];
    always_comb begin
        state_d     = state_q;
        is_lcu_d    = is_lcu_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        lambda_d    = lambda_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        buf_we_d    = 1'b0;
        err_d       = 1'b0;
        set_lambda  = 1'b0;
        set_lcu     = 1'b0;
        case (state_q)
            S_IDLE: if (acc) begin
                if (hdr_type == T_LAMBDA) begin
                    is_lcu_d = 1'b0;
                    state_d  = lambda_loaded_q ? S_WAIT : S_LAMBDA;
                end else if (hdr_type == T_LCU && hdr_n != 16'd0) begin
                    len_d = hdr_n;
                    cnt_d = 16'd0;
                    if ({1'b0, hdr_n} > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = S_DISCARD;
                    end else begin
                        is_lcu_d = 1'b1;
                        state_d  = lcu_loaded_q ? S_WAIT : S_LCU;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: if (is_lcu_q ? !lcu_loaded_q : !lambda_loaded_q) state_d = is_lcu_q ? S_LCU : S_LAMBDA;
            S_LAMBDA: if (acc) begin
                lambda_d   = channel_data;
                set_lambda = 1'b1;
                state_d    = S_IDLE;
            end
            S_LCU, S_DISCARD: if (acc) begin
                cnt_d = cnt_q + 16'd1;
                if (state_q == S_LCU) begin
                    buf_we_d    = 1'b1;
                    buf_addr_d  = cnt_q[ADDR_W-1:0];
                    buf_wdata_d = channel_data;
                end
                if (cnt_q == len_q - 16'd1) begin
                    set_lcu = state_q == S_LCU;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // a set in the same cycle as a clear leaves the flag high
        lambda_loaded_d = set_lambda | (lambda_loaded_q & ~lambda_clr);
        lcu_loaded_d    = set_lcu | (lcu_loaded_q & ~lcu_clr);
        if (sw_clear) begin
            state_d         = S_IDLE;
            cnt_d           = 16'd0;
            lambda_d        = lambda_q;
            lambda_loaded_d = 1'b0;
            lcu_loaded_d    = 1'b0;
            buf_we_d        = 1'b0;
            err_d           = 1'b0;
        end
        vz_d = (state_d != S_WAIT) && !sw_clear;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            is_lcu_q        <= 1'b0;
            len_q           <= 16'd0;
            cnt_q           <= 16'd0;
            lambda_q        <= 32'd0;
            lambda_loaded_q <= 1'b0;
            lcu_loaded_q    <= 1'b0;
            buf_we_q        <= 1'b0;
            buf_addr_q      <= '0;
            buf_wdata_q     <= 32'd0;
            err_q           <= 1'b0;
            vz_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            is_lcu_q        <= is_lcu_d;
            len_q           <= len_d;
            cnt_q           <= cnt_d;
            lambda_q        <= lambda_d;
            lambda_loaded_q <= lambda_loaded_d;
            lcu_loaded_q    <= lcu_loaded_d;
            buf_we_q        <= buf_we_d;
            buf_addr_q      <= buf_addr_d;
            buf_wdata_q     <= buf_wdata_d;
            err_q           <= err_d;
            vz_q            <= vz_d;
        end
    end
    assign channel_vz    = vz_q;
    assign lambda        = lambda_q;
    assign lambda_loaded = lambda_loaded_q;
    assign lcu_loaded    = lcu_loaded_q;
    assign buf_we        = buf_we_q;
    assign buf_addr      = buf_addr_q;
    assign buf_wdata     = buf_wdata_q;
    assign err           = err_q;
endmodule

// File: tb/tb_acc_config_rx.sv
// tb_acc_config_rx: directed and randomized packet bench with a packet-level reference model and write scoreboard.
module tb_acc_config_rx;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [31:0] channel_data = 32'd0;
    logic channel_lz = 1'b0, sw_clear = 1'b0, lambda_clr = 1'b0, lcu_clr = 1'b0;
    logic channel_vz, lambda_loaded, lcu_loaded, buf_we, err;
    logic [31:0] lambda, buf_wdata;
    logic [9:0] buf_addr;
    acc_config_rx #(.LCU_WORDS(1024), .ADDR_W(10)) dut (
        .clk(clk), .reset_n(reset_n), .channel_data(channel_data), .channel_lz(channel_lz),
        .channel_vz(channel_vz), .sw_clear(sw_clear), .lambda_clr(lambda_clr), .lcu_clr(lcu_clr),
        .lambda(lambda), .lambda_loaded(lambda_loaded), .lcu_loaded(lcu_loaded), .buf_we(buf_we),
        .buf_addr(buf_addr), .buf_wdata(buf_wdata), .err(err)
    );
    always #5 clk = ~clk;
    typedef struct {logic [9:0] a; logic [31:0] d; logic last;} wr_t;
    wr_t exp_q[$];
    int checks = 0, failures = 0, err_cnt = 0, err_exp = 0, we_cnt = 0, cyc = 0, last_we_cyc = 0;
    logic [31:0] lambda_m = 32'd0;
    logic lambda_loaded_m = 1'b0, lcu_loaded_m = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic put(input logic [31:0] w, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            channel_lz = 1'b0;
        end
        @(negedge clk);
        channel_lz = 1'b1;
        channel_data = w;
        n = 0;
        while (channel_vz !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("vz_timeout", {31'd0, channel_vz}, 32'd1);
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            channel_lz = 1'b0;
            channel_data = $urandom;
        end
    endtask
    task automatic pulse(input logic la, input logic lc);
        @(negedge clk);
        channel_lz = 1'b0;
        lambda_clr = la;
        lcu_clr = lc;
        @(negedge clk);
        lambda_clr = 1'b0;
        lcu_clr = 1'b0;
        if (la) lambda_loaded_m = 1'b0;
        if (lc) lcu_loaded_m = 1'b0;
    endtask
    task automatic check_model(input string tag);
        chk({tag, "_lambda"}, lambda, lambda_m);
        chk({tag, "_lambda_loaded"}, {31'd0, lambda_loaded}, {31'd0, lambda_loaded_m});
        chk({tag, "_lcu_loaded"}, {31'd0, lcu_loaded}, {31'd0, lcu_loaded_m});
        chk({tag, "_err_count"}, err_cnt, err_exp);
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (reset_n) begin
            if (err) err_cnt++;
            if (buf_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                if (exp_q.size() == 0) chk("unexpected_we", {31'd0, buf_we}, 32'd0);
                else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("we_addr", {22'd0, buf_addr}, {22'd0, e.a});
                    chk("we_data", buf_wdata, e.d);
                    chk("lcu_loaded_with_we", {31'd0, lcu_loaded}, {31'd0, e.last});
                end
            end
        end
    end
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        int w0, hdr_cyc, n;
        logic [31:0] v, bp[4], words[$];
        repeat (3) @(negedge clk);
        chk("rst_vz", {31'd0, channel_vz}, 32'd0);
        chk("rst_lambda", lambda, 32'd0);
        chk("rst_lambda_loaded", {31'd0, lambda_loaded}, 32'd0);
        chk("rst_lcu_loaded", {31'd0, lcu_loaded}, 32'd0);
        chk("rst_buf_we", {31'd0, buf_we}, 32'd0);
        chk("rst_buf_addr", {22'd0, buf_addr}, 32'd0);
        chk("rst_buf_wdata", buf_wdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("vz_after_reset", {31'd0, channel_vz}, 32'd1);
        // lambda load
        put(32'h1000_0000, 0);
        put(32'h0000_1234, 0);
        idle(1);
        lambda_m = 32'h1234;
        lambda_loaded_m = 1'b1;
        chk("lambda_value", lambda, 32'h1234);
        chk("lambda_loaded_set", {31'd0, lambda_loaded}, 32'd1);
        pulse(1'b1, 1'b0);
        chk("lambda_loaded_clr", {31'd0, lambda_loaded}, 32'd0);
        // full LCU, back-to-back
        for (int i = 0; i < 1024; i++) exp_q.push_back('{a: 10'(i), d: 32'(i), last: (i == 1023)});
        w0 = we_cnt;
        put(32'h2000_0400, 0);
        hdr_cyc = cyc;
        for (int i = 0; i < 1024; i++) put(32'(i), 0);
        idle(2);
        lcu_loaded_m = 1'b1;
        chk("full_lcu_writes", we_cnt - w0, 1024);
        chk("full_lcu_no_stall", last_we_cyc - hdr_cyc, 1025);
        check_model("full_lcu");
        // backpressure while the LCU is still loaded
        for (int i = 0; i < 4; i++) bp[i] = $urandom;
        w0 = we_cnt;
        put(32'h2000_0004, 0);
        @(negedge clk);
        channel_lz = 1'b1;
        channel_data = bp[0];
        chk("bp_vz_low0", {31'd0, channel_vz}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_vz_low", {31'd0, channel_vz}, 32'd0);
        end
        chk("bp_no_we", we_cnt - w0, 0);
        for (int i = 0; i < 4; i++) exp_q.push_back('{a: 10'(i), d: bp[i], last: (i == 3)});
        lcu_clr = 1'b1;
        @(negedge clk);
        lcu_clr = 1'b0;
        chk("bp_flag_drop", {31'd0, lcu_loaded}, 32'd0);
        chk("bp_vz_still_low", {31'd0, channel_vz}, 32'd0);
        @(negedge clk);
        chk("bp_vz_up", {31'd0, channel_vz}, 32'd1);
        for (int i = 1; i < 4; i++) put(bp[i], 0);
        idle(2);
        chk("bp_writes", we_cnt - w0, 4);
        check_model("bp");
        // illegal type, then a lambda packet parsed as a fresh header
        pulse(1'b0, 1'b1);
        put(32'h7000_0000, 0);
        err_exp++;
        v = $urandom;
        put(32'h1000_0000, 0);
        put(v, 0);
        idle(2);
        lambda_m = v;
        lambda_loaded_m = 1'b1;
        check_model("bad_type");
        // N = 0
        pulse(1'b1, 1'b0);
        put(32'h2000_0000, 0);
        err_exp++;
        v = $urandom;
        put(32'h1000_0000, 0);
        put(v, 0);
        idle(2);
        lambda_m = v;
        lambda_loaded_m = 1'b1;
        check_model("n_zero");
        // oversized LCU is discarded
        w0 = we_cnt;
        put(32'h2000_0500, 0);
        err_exp++;
        for (int i = 0; i < 1280; i++) put($urandom, 0);
        idle(2);
        chk("oversize_no_we", we_cnt - w0, 0);
        check_model("oversize");
        // abort after 10 of 64 words
        w0 = we_cnt;
        put(32'h2000_0040, 0);
        for (int i = 0; i < 10; i++) begin
            v = $urandom;
            exp_q.push_back('{a: 10'(i), d: v, last: 1'b0});
            put(v, 0);
        end
        @(negedge clk);
        channel_lz = 1'b1;
        channel_data = $urandom;
        sw_clear = 1'b1;
        @(negedge clk);
        sw_clear = 1'b0;
        channel_lz = 1'b0;
        lambda_loaded_m = 1'b0;
        lcu_loaded_m = 1'b0;
        chk("abort_vz_low", {31'd0, channel_vz}, 32'd0);
        chk("abort_writes", we_cnt - w0, 10);
        check_model("abort");
        @(negedge clk);
        chk("abort_vz_up", {31'd0, channel_vz}, 32'd1);
        v = $urandom;
        put(32'h1000_0000, 0);
        put(v, 0);
        idle(2);
        lambda_m = v;
        lambda_loaded_m = 1'b1;
        check_model("after_abort");
        // set/clear collision
        pulse(1'b1, 1'b0);
        put(32'h1000_0000, 0);
        v = $urandom;
        @(negedge clk);
        channel_lz = 1'b1;
        channel_data = v;
        lambda_clr = 1'b1;
        @(negedge clk);
        lambda_clr = 1'b0;
        channel_lz = 1'b0;
        lambda_m = v;
        lambda_loaded_m = 1'b1;
        check_model("collision");
        // randomized packet mix
        for (int p = 0; p < 40; p++) begin
            int kind, t;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                if (lambda_loaded_m) pulse(1'b1, 1'b0);
                v = $urandom;
                put({4'h1, 28'($urandom)}, $urandom_range(0, 2));
                put(v, $urandom_range(0, 2));
                lambda_m = v;
                lambda_loaded_m = 1'b1;
            end else if (kind == 1) begin
                if (lcu_loaded_m) pulse(1'b0, 1'b1);
                n = $urandom_range(1, 16);
                words = {};
                for (int i = 0; i < n; i++) begin
                    words.push_back($urandom);
                    exp_q.push_back('{a: 10'(i), d: words[i], last: (i == n - 1)});
                end
                put({4'h2, 12'($urandom), 16'(n)}, $urandom_range(0, 2));
                for (int i = 0; i < n; i++) put(words[i], $urandom_range(0, 2));
                lcu_loaded_m = 1'b1;
            end else if (kind == 2) begin
                t = $urandom_range(0, 13);
                t = (t == 0) ? 0 : t + 2;
                put({4'(t), 28'($urandom)}, $urandom_range(0, 2));
                err_exp++;
            end else begin
                n = $urandom_range(1025, 1040);
                put({4'h2, 12'($urandom), 16'(n)}, $urandom_range(0, 2));
                for (int i = 0; i < n; i++) put($urandom, $urandom_range(0, 1));
                err_exp++;
            end
            idle(2);
            check_model("random");
        end
        // asynchronous reset mid-packet
        pulse(1'b1, 1'b1);
        put(32'h2000_0008, 0);
        for (int i = 0; i < 3; i++) begin
            v = $urandom;
            exp_q.push_back('{a: 10'(i), d: v, last: 1'b0});
            put(v, 0);
        end
        idle(1);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_vz", {31'd0, channel_vz}, 32'd0);
        chk("midrst_lambda", lambda, 32'd0);
        chk("midrst_buf_we", {31'd0, buf_we}, 32'd0);
        chk("midrst_buf_addr", {22'd0, buf_addr}, 32'd0);
        reset_n = 1'b1;
        lambda_m = 32'd0;
        v = $urandom;
        put(32'h1000_0000, 0);
        put(v, 0);
        idle(2);
        lambda_m = v;
        lambda_loaded_m = 1'b1;
        check_model("after_midrst");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/acc_config_rx.md
# acc_config_rx

Accelerator-side receiver for the HPS configuration channel (32-bit data, `lz` strobe, `vz` ready). It parses packets carrying a SAD lambda value or an original-LCU pixel block. LCU payload words are written into the accelerator's block RAM, and the lambda is held in a register. It raises the `lambda_loaded`/`lcu_loaded` levels that the HPS polls through its PIOs, and it stalls the channel while a previous load has not yet been consumed.

## Interface
- `LCU_WORDS`, 1024: maximum LCU payload words (64x64 luma, 4 pixels/word).
- `ADDR_W`, 10: buffer address width, clog2(LCU_WORDS).
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `channel_data` in 32: channel word.
- `channel_lz` in 1: word valid.
- `channel_vz` out 1: ready. A word transfers on any cycle with `channel_lz & channel_vz`.
- `sw_clear` in 1: synchronous abort, level-sampled each cycle.
- `lambda_clr` in 1: pulse; lambda consumed.
- `lcu_clr` in 1: pulse; LCU consumed.
- `lambda` out 32: last received lambda.
- `lambda_loaded` out 1: level; `lambda` is valid and unconsumed.
- `lcu_loaded` out 1: level; buffer holds a complete LCU.
- `buf_we` out 1: buffer write enable.
- `buf_addr` out ADDR_W: buffer write address.
- `buf_wdata` out 32: buffer write data.
- `err` out 1: one-cycle pulse on a malformed header.

## Operation
- Header word fields:
  - [31:28] type: 0x1 LAMBDA, 0x2 LCU; any other value is illegal.
  - [15:0] N, the payload length in words; used by LCU only.
  - Other bits are ignored.
- FSM states: IDLE, WAIT, LAMBDA, LCU, DISCARD.
- IDLE, header accepted:
  - LAMBDA type: go to WAIT if `lambda_loaded`=1, else to LAMBDA.
  - LCU type with 1 <= N <= LCU_WORDS: go to WAIT if `lcu_loaded`=1, else to LCU. N is latched, and the word counter is cleared.
  - LCU type with N=0 or N>LCU_WORDS: `err` pulses. If N=0, stay in IDLE; otherwise go to DISCARD with count N.
  - Illegal type: `err` pulses and the FSM stays in IDLE. The header is consumed and no payload is assumed.
- WAIT:
  - `channel_vz`=0.
  - Leave for LAMBDA/LCU (by the latched type) once the corresponding loaded flag is 0.
- LAMBDA:
  - The next accepted word goes into `lambda`, and `lambda_loaded` is set.
  - Return to IDLE.
- LCU:
  - Each accepted word k (0..N-1) produces `buf_we`=1, `buf_addr`=k, `buf_wdata`=word.
  - On word N-1, set `lcu_loaded` and return to IDLE.
- DISCARD:
  - Accept and drop N words, then return to IDLE.
  - No `buf_we`, no flag change.
- Flags:
  - `lambda_clr` clears `lambda_loaded`; `lcu_clr` clears `lcu_loaded`.
  - A set and a clear of the same flag in the same cycle: set wins.
  - A clear while the flag is 0 has no effect.
- `sw_clear`:
  - FSM goes to IDLE, the counter clears, both loaded flags go to 0, and `buf_we`/`err` are forced to 0 next cycle.
  - `lambda` and buffer contents are retained.
  - `sw_clear` dominates every other event in that cycle. A word accepted in that cycle is dropped.
- `channel_vz`: a registered flop; next value = (next state != WAIT) & ~`sw_clear`.

## Timing
- Reset values:
  - `channel_vz`=0.
  - `lambda`=0, `lambda_loaded`=0, `lcu_loaded`=0.
  - `buf_we`=0, `buf_addr`=0, `buf_wdata`=0.
  - `err`=0.
  - FSM in IDLE.
- `channel_vz` rises on the first rising edge after `reset_n` deasserts.
- Throughput: one word per cycle in IDLE, LAMBDA, LCU and DISCARD; there are no bubbles between header and payload.
- Latency: all outputs are registered, one cycle after the accepting edge.
  - `buf_we`/`buf_addr`/`buf_wdata` appear the cycle after acceptance.
  - `lambda` and `lambda_loaded` update on the same edge.
  - `lcu_loaded` rises on the same edge as the `buf_we` of word N-1. The consumer must not read address N-1 before the next cycle.
  - `err` is high exactly one cycle, the cycle after the bad header.
- WAIT exit:
  - A clear pulse on cycle t drops the flag at edge t+1.
  - The FSM leaves WAIT at edge t+2.
  - `channel_vz`=1 from edge t+2.
- `channel_lz` high with `channel_vz`=0 transfers nothing; the sender holds the data.
- Asynchronous reset mid-packet abandons the packet. The next word is then parsed as a header.

## Test plan
- Lambda load: header 0x1000_0000, then 0x0000_1234 back-to-back. Expect `lambda`=0x1234 and `lambda_loaded`=1 two cycles after the header; `lambda_clr` returns the flag to 0.
- Full LCU: header 0x2000_0400, then 1024 words (value = index), `lz` held high. Expect 1024 consecutive `buf_we` with addr=data=0..1023, no stall, and `lcu_loaded`=1 with the addr-1023 write.
- Backpressure: with `lcu_loaded`=1, send header 0x2000_0004. Expect `channel_vz`=0 and no writes. Pulse `lcu_clr`. Expect `channel_vz`=1 two cycles later; the 4 words land at addr 0..3.
- Bad headers:
  - 0x7000_0000: one `err` pulse, the next word is treated as a header.
  - 0x2000_0500 followed by 1280 words: one `err` pulse, zero `buf_we`, `lcu_loaded` stays 0.
- Abort: `sw_clear` after 10 of 64 LCU words. Expect IDLE, flags 0, `lambda` unchanged; a following lambda packet is received correctly.
- Set/clear collision: `lambda_clr` pulsed on the same cycle a lambda payload is accepted while the flag is 0. Expect `lambda_loaded`=1.
